// File: rtl/sequencer_pkg.sv
// Shared constants for the two-LED step sequencer.
// Holds the default step timing and memory depth, the LED pattern width
// and the width of the spare LED bank.
`timescale 1ns/1ps
package sequencer_pkg;
    localparam int DEF_STEP_COUNTS = 6_000_000;  // 0.5 s per step at 12 MHz
    localparam int DEF_NUM_STEPS   = 8;
    localparam int PTN_W           = 2;          // one bit per LED
    localparam int UNUSED_LED_W    = 3;
endpackage

// File: rtl/sequencer_memory.sv
// Pattern store: MEM_DEPTH x MEM_WIDTH, one sync write port, one sync read port.
// Latency: r_data is valid one clk after r_addr/r_en; read-during-write returns old data.
// Backpressure: none; both ports accept one access every cycle.
//   clk            : system clock
//   w_en/w_addr/w_data : write port
//   r_en/r_addr/r_data : registered read port
`timescale 1ns/1ps
module sequencer_memory #(
    parameter int  MEM_WIDTH = 2,
    parameter int  MEM_DEPTH = 8,
    localparam int ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 w_en,
    input  logic [ADDR_W-1:0]    w_addr,
    input  logic [MEM_WIDTH-1:0] w_data,
    input  logic                 r_en,
    input  logic [ADDR_W-1:0]    r_addr,
    output logic [MEM_WIDTH-1:0] r_data
);
    // Power-up contents are zero; reset never touches the array so patterns
    // survive a mid-sequence reset.
    logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH] = '{default: '0};

    // Read and write share one block so the read samples the pre-write
    // word, which gives old-data semantics on an address collision.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_mem[w_addr] <= w_data;
        end
        if (r_en) begin
            r_data <= r_mem[r_addr];
        end
    end
endmodule

// File: rtl/sequencer_top.sv
// Board top: step timer walks a pattern memory and drives two LEDs; buttons record patterns.
// Latency: led shows mem[step] 1 clk after step changes; button press to write is 3 clk.
// Backpressure: none; buttons are sampled every cycle, one write per set_btn press.
//   clk                         : 12 MHz system clock
//   rst_btn                     : synchronous active-low reset
//   set_btn, ptn_0_btn, ptn_1_btn : active-low push buttons
//   led                         : current step pattern, 1 = on
//   unused_led                  : spare LEDs, held off
`timescale 1ns/1ps
module sequencer_top
    import sequencer_pkg::*;
#(
    parameter int STEP_COUNTS = DEF_STEP_COUNTS,
    parameter int NUM_STEPS   = DEF_NUM_STEPS
) (
    input  logic                    clk,
    input  logic                    rst_btn,
    input  logic                    set_btn,
    input  logic                    ptn_0_btn,
    input  logic                    ptn_1_btn,
    output logic [PTN_W-1:0]        led,
    output logic [UNUSED_LED_W-1:0] unused_led
);
    localparam int CNT_W  = $clog2(STEP_COUNTS);
    localparam int STEP_W = $clog2(NUM_STEPS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEP_COUNTS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

    // Button synchronizers idle high (released); r_set_prev extends the
    // set chain by one stage for falling-edge detection.
    logic             r_set_meta = 1'b1;
    logic             r_set_sync = 1'b1;
    logic             r_set_prev = 1'b1;
    logic [PTN_W-1:0] r_ptn_meta = '1;
    logic [PTN_W-1:0] r_ptn_sync = '1;

    logic [CNT_W-1:0]  r_cycle_cnt = '0;
    logic [STEP_W-1:0] r_step      = '0;
    // The RAM read register has no reset, so led is gated until the first
    // post-reset read of mem[step] has landed.
    logic              r_led_vld   = 1'b0;

    logic              w_step_end;
    logic              w_wr_en;
    logic [PTN_W-1:0]  w_wr_data;
    logic [PTN_W-1:0]  w_rd_data;

    assign w_step_end = (r_cycle_cnt == CNT_LAST);
    assign w_wr_en    = r_set_prev & ~r_set_sync;
    assign w_wr_data  = ~r_ptn_sync;            // buttons are active-low

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            r_set_meta  <= 1'b1;
            r_set_sync  <= 1'b1;
            r_set_prev  <= 1'b1;
            r_ptn_meta  <= '1;
            r_ptn_sync  <= '1;
            r_cycle_cnt <= '0;
            r_step      <= '0;
            r_led_vld   <= 1'b0;
        end else begin
            r_set_meta  <= set_btn;
            r_set_sync  <= r_set_meta;
            r_set_prev  <= r_set_sync;
            r_ptn_meta  <= {ptn_1_btn, ptn_0_btn};
            r_ptn_sync  <= r_ptn_meta;
            r_led_vld   <= 1'b1;
            if (w_step_end) begin
                r_cycle_cnt <= '0;
                r_step      <= (r_step == STEP_LAST) ? '0 : r_step + STEP_W'(1);
            end else begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
        end
    end

    // Write address is the current (pre-advance) step, so a write that
    // coincides with a step boundary lands in the step being left.
    sequencer_memory #(
        .MEM_WIDTH (PTN_W),
        .MEM_DEPTH (NUM_STEPS)
    ) u_mem (
        .clk    (clk),
        .w_en   (w_wr_en),
        .w_addr (r_step),
        .w_data (w_wr_data),
        .r_en   (1'b1),
        .r_addr (r_step),
        .r_data (w_rd_data)
    );

    assign led        = r_led_vld ? w_rd_data : '0;
    assign unused_led = '0;
endmodule

// File: tb/tb_sequencer_top.sv
`timescale 1ns/1ps
module tb_sequencer_top;
    localparam int SC = 10;
    localparam int NS = 8;

    logic       clk = 1'b0;
    logic       rst_btn = 1'b0;
    logic       set_btn = 1'b1;
    logic       ptn_0_btn = 1'b1;
    logic       ptn_1_btn = 1'b1;
    logic [1:0] led;
    logic [2:0] unused_led;

    sequencer_top #(.STEP_COUNTS(SC), .NUM_STEPS(NS)) dut (
        .clk        (clk),
        .rst_btn    (rst_btn),
        .set_btn    (set_btn),
        .ptn_0_btn  (ptn_0_btn),
        .ptn_1_btn  (ptn_1_btn),
        .led        (led),
        .unused_led (unused_led)
    );

    always #41.67 clk = ~clk;

    typedef struct {
        int         step;
        logic [1:0] ptn;
    } wr_vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    // Reference model: m_k = clk edges since the last reset edge.
    int         m_k     = 0;
    int         pend_k  = -1;
    logic [1:0] pend_d  = 2'b00;
    logic [1:0] exp_mem [NS];
    logic [1:0] q_led [$];
    int         q_step [$];

    wr_vec_t    wr_tbl [3];
    logic [1:0] tbl_one  [NS];
    logic [1:0] tbl_three[NS];
    logic [1:0] tbl_held [NS];

    function automatic int m_step();
        return (m_k / SC) % NS;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: predict led/step at the edge, push to the scoreboard,
    // then pop and compare on the falling edge.
    task automatic tick();
        logic [1:0] e;
        int         a;
        @(posedge clk);
        if (!rst_btn) begin
            m_k = 0;
            e   = 2'b00;
        end else begin
            m_k++;
            a = ((m_k - 1) / SC) % NS;   // step held during the cycle before this edge
            e = exp_mem[a];              // read returns pre-write data
            if (m_k == pend_k) begin
                exp_mem[a] = pend_d;
                pend_k     = -1;
            end
        end
        q_led.push_back(e);
        q_step.push_back(m_step());
        @(negedge clk);
        chk("led", int'(led), int'(q_led.pop_front()));
        chk("step", int'(dut.r_step), q_step.pop_front());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_at(input int s, input int off);
        int guard;
        guard = 0;
        while (!(m_step() == s && (m_k % SC) == off) && guard < 300) begin
            tick();
            guard++;
        end
        if (guard >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_step: step %0d offset %0d not reached, required %0d/%0d", m_step(), m_k % SC, s, off);
        end
    endtask

    // Press set with a pattern; the write is expected 3 edges later.
    task automatic press(input logic [1:0] p);
        set_btn   = 1'b0;
        ptn_0_btn = ~p[0];
        ptn_1_btn = ~p[1];
        pend_k    = m_k + 3;
        pend_d    = p;
    endtask

    task automatic release_btns();
        set_btn   = 1'b1;
        ptn_0_btn = 1'b1;
        ptn_1_btn = 1'b1;
    endtask

    // Sample the middle of each step window against a fixed pattern table.
    task automatic check_loop(input logic [1:0] tbl [NS]);
        for (int s = 0; s < NS; s++) begin
            wait_at(s, 5);
            chk("loop_led", int'(led), int'(tbl[s]));
            chk("loop_unused", int'(unused_led), 0);
        end
    endtask

    initial begin
        foreach (exp_mem[i]) exp_mem[i] = 2'b00;
        wr_tbl[0] = '{2, 2'b01};
        wr_tbl[1] = '{5, 2'b11};
        wr_tbl[2] = '{7, 2'b10};
        tbl_one   = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl_three = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10};
        tbl_held  = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b11, 2'b00, 2'b10};

        // Reset held across two edges.
        rst_btn = 1'b0;
        ticks(2);
        chk("rst_led", int'(led), 0);
        chk("rst_unused", int'(unused_led), 0);
        chk("rst_step", int'(dut.r_step), 0);
        rst_btn = 1'b1;

        // Empty memory: led stays dark while step walks and wraps twice.
        ticks(200);
        chk("empty_unused", int'(unused_led), 0);

        // First recording, then the loop shows it only in step 2.
        wait_at(wr_tbl[0].step, 1);
        press(wr_tbl[0].ptn);
        ticks(4);
        release_btns();
        check_loop(tbl_one);

        for (int i = 1; i < 3; i++) begin
            wait_at(wr_tbl[i].step, 1);
            press(wr_tbl[i].ptn);
            ticks(4);
            release_btns();
        end
        check_loop(tbl_three);
        check_loop(tbl_three);

        // One-cycle reset mid-step 6: restart at step 0, memory kept.
        wait_at(6, 3);
        rst_btn = 1'b0;
        tick();
        rst_btn = 1'b1;
        chk("midrst_led", int'(led), 0);
        chk("midrst_step", int'(dut.r_step), 0);
        tick();
        chk("midrst_step_hold", int'(dut.r_step), 0);
        check_loop(tbl_three);

        // set held low across three step boundaries: only step 3 changes.
        wait_at(3, 1);
        press(2'b11);
        ticks(35);
        release_btns();
        ticks(3);
        check_loop(tbl_held);
        check_loop(tbl_held);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
